red_pitaya_dfilt_cfg_ctrl: RTL and testbench
============================================

RED_PITAYA_DFILT_CFG_CTRL -- requirements
Module: red_pitaya_dfilt_cfg_ctrl

Interface
REQ-001 SHALL have port adc_clk_i, input, 1: sole clock; all logic rising-edge.
REQ-002 SHALL have port adc_rstn_i, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port wr_en_i, input, 1: shadow-register write strobe.
REQ-004 SHALL have port wr_addr_i, input, 2: shadow select; 0=aa, 1=bb, 2=kk, 3=pp.
REQ-005 SHALL have port wr_data_i, input, 25: write data; aa takes [17:0], others take [24:0].
REQ-006 SHALL have port commit_i, input, 1: request to apply shadow set to filter.
REQ-007 SHALL have port settle_i, input, 16: post-flush mute length in cycles.
REQ-008 SHALL have ports cfg_aa_o (18), cfg_bb_o (25), cfg_kk_o (25), cfg_pp_o (25), outputs: active coefficients to the filter.
REQ-009 SHALL have port filt_rstn_o, output, 1: active-low filter state flush.
REQ-010 SHALL have port mute_o, output, 1: downstream selects zero instead of filter output.
REQ-011 SHALL have ports busy_o, done_o, pend_o, outputs, 1 each: sequence active; one-cycle completion pulse; shadow written since last accepted commit.

Function
REQ-012 SHALL hold shadow and active register sets; only shadows are writable.
REQ-013 SHALL update the addressed shadow on the edge where wr_en_i=1, in any state.
REQ-014 SHALL implement FSM IDLE -> FLUSH -> SETTLE -> DONE -> IDLE.
REQ-015 SHALL, when commit_i=1 in IDLE at edge N, copy all four shadows to active registers atomically, latch settle_i, clear pend_o, and enter FLUSH; outputs change at N+1.
REQ-016 SHALL use the shadow values registered before edge N; a write at edge N is excluded from that commit and sets pend_o=1.
REQ-017 SHALL drive filt_rstn_o=0 for exactly 4 cycles in FLUSH (cycles N+1..N+4).
REQ-018 SHALL stay in SETTLE for the latched settle count; count 0 skips SETTLE, FLUSH goes straight to DONE.
REQ-019 SHALL assert mute_o in FLUSH and SETTLE; deassert in DONE.
REQ-020 SHALL assert busy_o in FLUSH, SETTLE and DONE; done_o=1 only in DONE (cycle N+5+settle).
REQ-021 SHALL latch at most one commit_i arriving while busy; after DONE, take it as an IDLE commit with the then-current shadows; further commits while one is latched SHALL be dropped.
REQ-022 SHALL set pend_o on every shadow write and clear it only when a commit is accepted, not when latched.
REQ-023 SHALL keep settle_i changes during a sequence from affecting that sequence.

Reset
REQ-024 SHALL, on adc_rstn_i=0, asynchronously set shadow and active aa=18'h07D93, bb=25'h00437C7, kk=25'h0D9999A, pp=25'h0002666; FSM=IDLE; latched commit and settle cleared.
REQ-025 SHALL drive filt_rstn_o=0 and mute_o=1 while in reset; busy_o=0, done_o=0, pend_o=0.
REQ-026 SHALL, on reset release, drive filt_rstn_o=1 and mute_o=0 from the first clock edge.
REQ-027 SHALL abort an in-progress sequence on reset; reset values win.

Verification
REQ-028 SHALL test: reset release -> outputs equal REQ-024 defaults; filt_rstn_o=1, mute_o=0, busy_o=0.
REQ-029 SHALL test: write kk=25'h1000000, settle_i=10, commit at edge N -> cfg_kk_o=25'h1000000 at N+1; filt_rstn_o low N+1..N+4; mute_o high N+1..N+14; done_o at N+15 only.
REQ-030 SHALL test: settle_i=0, commit -> done_o at N+5; mute_o high exactly 4 cycles.
REQ-031 SHALL test: write aa=18'h00100 on the same edge as commit -> cfg_aa_o stays 18'h07D93; pend_o=1; a second commit applies 18'h00100.
REQ-032 SHALL test: three commits during SETTLE -> exactly one extra sequence after DONE; two done_o pulses total.
REQ-033 SHALL test: adc_rstn_i low at cycle N+2 of a sequence -> immediate defaults; busy_o=0; no done_o.

Source files
------------

// File: rtl/red_pitaya_dfilt_cfg_ctrl.sv
// Coefficient shadow/active register bank for the Red Pitaya decimation filter,
// with a commit sequencer that flushes the filter and mutes its output while new taps settle.
module red_pitaya_dfilt_cfg_ctrl (
    input  logic        adc_clk_i,
    input  logic        adc_rstn_i,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_addr_i,
    input  logic [24:0] wr_data_i,
    input  logic        commit_i,
    input  logic [15:0] settle_i,
    output logic [17:0] cfg_aa_o,
    output logic [24:0] cfg_bb_o,
    output logic [24:0] cfg_kk_o,
    output logic [24:0] cfg_pp_o,
    output logic        filt_rstn_o,
    output logic        mute_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pend_o,
    output logic [1:0]  fsm_state_o
);

    // Handshake: commit_i is a level sampled on each rising edge; it is accepted
    // only in IDLE, otherwise one request is remembered and replayed after DONE.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [17:0] AA_RST = 18'h07D93;
    localparam logic [24:0] BB_RST = 25'h00437C7;
    localparam logic [24:0] KK_RST = 25'h0D9999A;
    localparam logic [24:0] PP_RST = 25'h0002666;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] settle_q;
    logic        cmt_q, cmt_d;
    logic        pend_q;
    logic        run_q;
    logic        accept;

    logic [17:0] sh_aa_q, act_aa_q;
    logic [24:0] sh_bb_q, act_bb_q;
    logic [24:0] sh_kk_q, act_kk_q;
    logic [24:0] sh_pp_q, act_pp_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_i || cmt_q) begin
                    accept  = 1'b1;
                    state_d = FLUSH;
                    cnt_d   = 16'd0;
                end
            end
            FLUSH: begin
                // Four flush cycles: counter walks 0..3 before leaving.
                if (cnt_q[1:0] == 2'd3) begin
                    if (settle_q == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == settle_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cmt_d = cmt_q;
        if (accept) begin
            cmt_d = 1'b0;
        end else if (state_q != IDLE && commit_i) begin
            cmt_d = 1'b1;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            settle_q <= 16'd0;
            cmt_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmt_q   <= cmt_d;
            run_q   <= 1'b1;
            if (accept) begin
                settle_q <= settle_i;
            end
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            sh_aa_q <= AA_RST;
            sh_bb_q <= BB_RST;
            sh_kk_q <= KK_RST;
            sh_pp_q <= PP_RST;
            pend_q  <= 1'b0;
        end else begin
            if (wr_en_i) begin
                case (wr_addr_i)
                    2'd0:    sh_aa_q <= wr_data_i[17:0];
                    2'd1:    sh_bb_q <= wr_data_i;
                    2'd2:    sh_kk_q <= wr_data_i;
                    default: sh_pp_q <= wr_data_i;
                endcase
            end
            // A write on the accepting edge belongs to the next commit.
            if (wr_en_i) begin
                pend_q <= 1'b1;
            end else if (accept) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            act_aa_q <= AA_RST;
            act_bb_q <= BB_RST;
            act_kk_q <= KK_RST;
            act_pp_q <= PP_RST;
        end else if (accept) begin
            act_aa_q <= sh_aa_q;
            act_bb_q <= sh_bb_q;
            act_kk_q <= sh_kk_q;
            act_pp_q <= sh_pp_q;
        end
    end

    // run_q keeps the filter flushed and muted until the first edge after reset.
    assign filt_rstn_o = run_q && (state_q != FLUSH);
    assign mute_o      = !run_q || (state_q == FLUSH) || (state_q == SETTLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign pend_o      = pend_q;
    assign fsm_state_o = state_q;

    assign cfg_aa_o = act_aa_q;
    assign cfg_bb_o = act_bb_q;
    assign cfg_kk_o = act_kk_q;
    assign cfg_pp_o = act_pp_q;

endmodule

// File: tb/tb_red_pitaya_dfilt_cfg_ctrl.sv
// Directed bench for the filter coefficient commit controller.
module tb_red_pitaya_dfilt_cfg_ctrl;

    logic        clk;
    logic        rstn;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [24:0] wr_data;
    logic        commit;
    logic [15:0] settle;
    logic [17:0] cfg_aa;
    logic [24:0] cfg_bb;
    logic [24:0] cfg_kk;
    logic [24:0] cfg_pp;
    logic        filt_rstn;
    logic        mute;
    logic        busy;
    logic        done;
    logic        pend;
    logic [1:0]  fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    red_pitaya_dfilt_cfg_ctrl dut (
        .adc_clk_i   (clk),
        .adc_rstn_i  (rstn),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .commit_i    (commit),
        .settle_i    (settle),
        .cfg_aa_o    (cfg_aa),
        .cfg_bb_o    (cfg_bb),
        .cfg_kk_o    (cfg_kk),
        .cfg_pp_o    (cfg_pp),
        .filt_rstn_o (filt_rstn),
        .mute_o      (mute),
        .busy_o      (busy),
        .done_o      (done),
        .pend_o      (pend),
        .fsm_state_o (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [24:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic check_defaults(input string tag);
        check({tag, "_aa"}, 32'(cfg_aa), 32'h07D93);
        check({tag, "_bb"}, 32'(cfg_bb), 32'h00437C7);
        check({tag, "_kk"}, 32'(cfg_kk), 32'h0D9999A);
        check({tag, "_pp"}, 32'(cfg_pp), 32'h0002666);
    endtask

    // Commit with settle count s, then follow the sequence cycle by cycle.
    // Cycle c is observed just after edge N+c-1; settle_i is disturbed mid-run.
    task automatic do_commit(input int s);
        settle = 16'(s);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr_en  = 1'b0;
        settle = 16'(s + 3);
        for (int c = 1; c <= s + 6; c++) begin
            check("seq_filt_rstn", 32'(filt_rstn), (c <= 4) ? 32'd0 : 32'd1);
            check("seq_mute", 32'(mute), (c <= 4 + s) ? 32'd1 : 32'd0);
            check("seq_busy", 32'(busy), (c <= 5 + s) ? 32'd1 : 32'd0);
            check("seq_done", 32'(done), (c == 5 + s) ? 32'd1 : 32'd0);
            if (c < s + 6) tick();
        end
    endtask

    initial begin
        int done_cnt;
        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 25'd0;
        commit  = 1'b0;
        settle  = 16'd0;

        // Held in reset: filter flushed and muted
        #3;
        check("rst_filt_rstn", 32'(filt_rstn), 32'd0);
        check("rst_mute", 32'(mute), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        #10;
        rstn = 1'b1;
        tick();
        check_defaults("rel");
        check("rel_filt_rstn", 32'(filt_rstn), 32'd1);
        check("rel_mute", 32'(mute), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_done", 32'(done), 32'd0);
        check("rel_pend", 32'(pend), 32'd0);

        // kk write, then commit with settle 10
        write_reg(2'd2, 25'h1000000);
        check("wr_pend", 32'(pend), 32'd1);
        check("wr_kk_not_active", 32'(cfg_kk), 32'h0D9999A);
        do_commit(10);
        check("c1_kk", 32'(cfg_kk), 32'h1000000);
        check("c1_aa", 32'(cfg_aa), 32'h07D93);
        check("c1_pend", 32'(pend), 32'd0);

        // settle 0 skips SETTLE
        do_commit(0);

        // aa written on the commit edge is excluded
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 25'h0000100;
        do_commit(0);
        check("same_edge_aa", 32'(cfg_aa), 32'h07D93);
        check("same_edge_pend", 32'(pend), 32'd1);
        do_commit(0);
        check("second_aa", 32'(cfg_aa), 32'h00100);
        check("second_pend", 32'(pend), 32'd0);

        // Three commits during SETTLE collapse to one replay
        settle = 16'd3;
        commit = 1'b1;
        tick();
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) done_cnt++;
            if (c == 8)  check("multi_done1", 32'(done), 32'd1);
            if (c == 9)  check("multi_idle_gap", 32'(busy), 32'd0);
            if (c == 10) check("multi_restart", 32'(filt_rstn), 32'd0);
            if (c == 17) check("multi_done2", 32'(done), 32'd1);
            commit = (c >= 5 && c <= 7);
            tick();
        end
        commit = 1'b0;
        check("multi_done_count", 32'(done_cnt), 32'd2);

        // Reset during FLUSH aborts and restores defaults, shadows included
        write_reg(2'd3, 25'h1234567);
        settle = 16'd5;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("ab_pp_applied", 32'(cfg_pp), 32'h1234567);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check_defaults("ab");
        check("ab_filt_rstn", 32'(filt_rstn), 32'd0);
        check("ab_mute", 32'(mute), 32'd1);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        check("ab_pend", 32'(pend), 32'd0);
        #2;
        rstn = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("ab_no_activity", 32'(done_cnt), 32'd0);
        check("ab_filt_after", 32'(filt_rstn), 32'd1);
        check("ab_mute_after", 32'(mute), 32'd0);
        do_commit(0);
        check("ab_shadow_pp", 32'(cfg_pp), 32'h0002666);
        check("ab_shadow_aa", 32'(cfg_aa), 32'h07D93);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
